// File: rtl/booth2_wallace_pipe_pkg.sv
// Shared constants, row type and weighting helper for the Booth radix-4 Wallace reducer.
package booth_mult_pkg;

  localparam int unsigned PP_W     = 17;
  localparam int unsigned P_W      = 32;
  localparam int unsigned PP_NUM   = 8;
  localparam int unsigned PP_SHIFT = 2;

  typedef logic [P_W-1:0] row_t;

  // Sign-extend a partial product to full width and apply its 4^idx weight.
  function automatic row_t weigh_pp(input logic [PP_W-1:0] pp, input int unsigned idx);
    row_t ext;
    ext = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
    return ext << (PP_SHIFT * idx);
  endfunction

endpackage

// File: rtl/booth2_wallace_pipe_if.sv
// Handshake bus between the Booth PP generator, the Wallace reducer and the product consumer.
interface booth2_wallace_pipe_if;
  import booth_mult_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [PP_W-1:0] PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8;
  logic            out_valid;
  logic            out_ready;
  row_t            product;

  modport master (
    output in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/booth2_wallace_pipe_csa.sv
// Width-parameterised 3:2 carry-save adder; carry output is already weighted (shifted left by 1).
module csa_3_2 #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  output logic [Width-1:0] sum_o,
  output logic [Width-1:0] carry_o
);

  logic [Width-1:0] maj;

  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    carry_o = {maj[Width-2:0], 1'b0};
  end

endmodule

// File: rtl/booth2_wallace_pipe.sv
// Pipelined Wallace-tree reducer: 8 Booth PPs -> 4 rows (S1) -> 2 rows (S2) -> CPA product.
// Define BOOTH_WALLACE_OUT_REG_EN to register the CPA result as a third stage.
module booth2_wallace_pipe
  import booth_mult_pkg::*;
(
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  booth2_wallace_pipe_if.slave bus
);

  row_t rows [PP_NUM];

  always_comb begin
    rows[0] = weigh_pp(bus.PP1, 0);
    rows[1] = weigh_pp(bus.PP2, 1);
    rows[2] = weigh_pp(bus.PP3, 2);
    rows[3] = weigh_pp(bus.PP4, 3);
    rows[4] = weigh_pp(bus.PP5, 4);
    rows[5] = weigh_pp(bus.PP6, 5);
    rows[6] = weigh_pp(bus.PP7, 6);
    rows[7] = weigh_pp(bus.PP8, 7);
  end

  // Stage 1 tree: 8 -> 6 -> 4 rows
  row_t sa_sum, sa_carry, sb_sum, sb_carry, sc_sum, sc_carry, sd_sum, sd_carry;

  csa_3_2 #(.Width(P_W)) u_csa_a (
    .a_i(rows[0]), .b_i(rows[1]), .c_i(rows[2]), .sum_o(sa_sum), .carry_o(sa_carry)
  );
  csa_3_2 #(.Width(P_W)) u_csa_b (
    .a_i(rows[3]), .b_i(rows[4]), .c_i(rows[5]), .sum_o(sb_sum), .carry_o(sb_carry)
  );
  csa_3_2 #(.Width(P_W)) u_csa_c (
    .a_i(sa_sum), .b_i(sa_carry), .c_i(sb_sum), .sum_o(sc_sum), .carry_o(sc_carry)
  );
  csa_3_2 #(.Width(P_W)) u_csa_d (
    .a_i(sb_carry), .b_i(rows[6]), .c_i(rows[7]), .sum_o(sd_sum), .carry_o(sd_carry)
  );

  row_t [3:0] s1_row_q, s1_row_d;
  logic       s1_v_q, s1_v_d;

  // Stage 2 tree: 4 -> 3 -> 2 rows
  row_t se_sum, se_carry, s2_sum_d, s2_carry_d, s2_sum_q, s2_carry_q;
  logic s2_v_q, s2_v_d;

  csa_3_2 #(.Width(P_W)) u_csa_e (
    .a_i(s1_row_q[0]), .b_i(s1_row_q[1]), .c_i(s1_row_q[2]),
    .sum_o(se_sum), .carry_o(se_carry)
  );
  csa_3_2 #(.Width(P_W)) u_csa_f (
    .a_i(se_sum), .b_i(se_carry), .c_i(s1_row_q[3]),
    .sum_o(s2_sum_d), .carry_o(s2_carry_d)
  );

  row_t cpa_sum;
  logic s1_ready, s2_ready, s3_ready;

  assign cpa_sum = s2_sum_q + s2_carry_q;

  // Ready chain is purely combinational from the output back to in_ready.
  assign s1_ready     = ~s1_v_q | s2_ready;
  assign s2_ready     = ~s2_v_q | s3_ready;
  assign bus.in_ready = s1_ready;

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_row_d = s1_row_q;
    if (s1_ready) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) s1_row_d = {sd_carry, sd_sum, sc_carry, sc_sum};
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    if (s2_ready) s2_v_d = s1_v_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_v_q     <= 1'b0;
      s1_row_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_row_q <= s1_row_d;
      s2_v_q   <= s2_v_d;
      if (s2_ready && s1_v_q) begin
        s2_sum_q   <= s2_sum_d;
        s2_carry_q <= s2_carry_d;
      end
    end
  end

`ifdef BOOTH_WALLACE_OUT_REG_EN
  row_t out_reg_q, out_reg_d;
  logic out_v_q, out_v_d;

  assign s3_ready = ~out_v_q | bus.out_ready;

  always_comb begin
    out_v_d   = out_v_q;
    out_reg_d = out_reg_q;
    if (s3_ready) begin
      out_v_d = s2_v_q;
      if (s2_v_q) out_reg_d = cpa_sum;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_v_q   <= 1'b0;
      out_reg_q <= '0;
    end else begin
      out_v_q   <= out_v_d;
      out_reg_q <= out_reg_d;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.product   = out_reg_q;
`else
  assign s3_ready      = bus.out_ready;
  assign bus.out_valid = s2_v_q;
  assign bus.product   = cpa_sum;
`endif

endmodule

// File: tb/tb_booth2_wallace_pipe.sv
// Directed bench for booth2_wallace_pipe: known vectors, streaming, stall/drain and mid-flight reset.
module tb_booth2_wallace_pipe;
  import booth_mult_pkg::*;

`ifdef BOOTH_WALLACE_OUT_REG_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  typedef logic [16:0] pp_set_t [8];

  logic sys_clk;
  logic sys_rst_n;
  int   errors;
  int   checks;

  booth2_wallace_pipe_if bus ();

  booth2_wallace_pipe u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference arithmetic: sign-extend, weight by 4^i, sum modulo 2^32.
  function automatic logic [31:0] model(input pp_set_t p);
    logic [31:0] acc;
    logic [31:0] ext;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      ext = {{15{p[i][16]}}, p[i]};
      acc = acc + (ext << (2 * i));
    end
    return acc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input pp_set_t p);
    bus.PP1 = p[0]; bus.PP2 = p[1]; bus.PP3 = p[2]; bus.PP4 = p[3];
    bus.PP5 = p[4]; bus.PP6 = p[5]; bus.PP7 = p[6]; bus.PP8 = p[7];
  endtask

  // Called at a negedge with an empty pipeline and out_ready=1.
  task automatic single(input string tag, input pp_set_t p, input logic [31:0] exp);
    int n;
    drive(p);
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge sys_clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 12) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_latency"}, n, Lat);
    check(tag, bus.product, exp);
    @(negedge sys_clk);
  endtask

  pp_set_t v;
  pp_set_t rs [8];
  pp_set_t st [4];
  logic [31:0] held;
  int acc, got;
  logic exp_v;

  initial begin
    errors        = 0;
    checks        = 0;
    sys_rst_n     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    v = '{default: '0};
    drive(v);
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_product", bus.product, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    v = '{default: '0}; v[0] = 17'h1FFFB; v[1] = 17'h00005;
    single("neg_plus", v, 32'h0000000F);
    v = '{default: 17'h00001};
    single("all_ones", v, 32'h00005555);
    v = '{default: '0}; v[7] = 17'h1FFFF;
    single("pp8_neg", v, 32'hFFFFC000);
    v = '{default: '0}; v[0] = 17'h0FFFF;
    single("pp1_max", v, 32'h0000FFFF);

    // Back-to-back stream, one product per cycle.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rs[i][j] = 17'($urandom);
    for (int c = 0; c < 8 + Lat + 1; c++) begin
      exp_v = (c >= Lat) && (c < Lat + 8);
      check("stream_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
      if (exp_v) check("stream_product", bus.product, model(rs[c-Lat]));
      if (c < 8) begin
        drive(rs[c]);
        bus.in_valid = 1'b1;
        check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge sys_clk);
    end

    // Stall: fill every stage, then drain in order.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) st[i][j] = 17'($urandom);
    bus.out_ready = 1'b0;
    acc  = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      if (bus.in_ready && acc < 4) begin
        drive(st[acc]);
        bus.in_valid = 1'b1;
        acc++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge sys_clk);
      if (c == Lat - 1) held = bus.product;
      if (c >= Lat) check("stall_stable", bus.product, held);
    end
    bus.in_valid = 1'b0;
    check("stall_accepts", acc, Lat);
    check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("stall_head", bus.product, model(st[0]));
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < Lat + 3; c++) begin
      if (bus.out_valid) begin
        if (got < 4) check("drain_product", bus.product, model(st[got]));
        got++;
      end
      @(negedge sys_clk);
    end
    check("drain_count", got, Lat);

    // Reset with two products in flight.
    drive(rs[0]);
    bus.in_valid = 1'b1;
    @(negedge sys_clk);
    drive(rs[1]);
    @(negedge sys_clk);
    bus.in_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    single("post_rst", rs[2], model(rs[2]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth2_wallace_pipe.md
# booth2_wallace_pipe

Pipelined Wallace-tree reducer for the 16×16 Booth radix-4 multiplier. It sits directly downstream of the Booth partial-product generator and accepts its eight 17-bit partial products under a valid/ready handshake. It compresses them through registered carry-save stages and delivers the 32-bit two's-complement product. Backpressure propagates stage by stage, so one product per cycle is sustained when the output is not stalled.

## Interface
- `PP_W`, 17: partial-product width (signed).
- `P_W`, 32: product width.
- `sys_clk` in 1: clock, rising edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: `PP1`..`PP8` valid this cycle.
- `in_ready` out 1: stage 1 can accept.
- `PP1`..`PP8` in 17 each: partial products. `PPi` is a signed 17-bit value with weight 2^(2(i-1)).
- `out_valid` out 1: `product` valid.
- `out_ready` in 1: consumer accepts.
- `product` out 32: sum of all weighted PPs, modulo 2^32.

## Operation
- Transfer occurs on any edge where valid && ready.
- Arithmetic:
  - Each `PPi` is sign-extended from bit 16 to 32 bits, then shifted left by 2(i-1).
  - `product` = Σ(extended, shifted PPi) mod 2^32. Carries out of bit 31 are discarded.
- Stage 1 (S1), registered:
  - Eight rows reduce to six with two 3:2 CSAs (rows 7 and 8 pass through).
  - Six rows reduce to four with two 3:2 CSAs.
  - Registers: `s1_row[0:3]` (32 b each), `s1_v`.
- Stage 2 (S2), registered:
  - Four rows reduce to three, then three reduce to two.
  - Registers: `s2_sum`, `s2_carry`, `s2_v`.
- Stage 3 (S3): 32-bit carry-propagate add, `s2_sum` + `s2_carry`. Registered or not depending on configuration.
- Stall logic, one valid bit per register stage k:
  - ready_k = ~v_k | ready_{k+1}.
  - The last stage's ready_{k+1} is `out_ready`.
  - `in_ready` = ready_S1.
  - Stage k loads when ready_k. It loads the upstream valid and data, or clears v_k if upstream is not presenting.
- The ready chain is combinational. No skid buffer.
- Data registers may hold stale values while their v is 0. Only valid bits require reset.
- No state machine beyond per-stage valid bits.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - All valid bits 0.
  - `product`=0 when the output register is present. Otherwise it is a combinational function of the stage-2 registers, which reset to 0.
- Latency from an accepted input to `out_valid`:
  - 3 cycles with `BOOTH_WALLACE_OUT_REG_EN`.
  - 2 cycles without it.
- Throughput is 1 product per cycle while `out_ready`=1.
- Output stalled (`out_ready`=0): `product` and `out_valid` hold stable. Upstream stages fill. `in_ready` drops only when every stage is valid.
- Simultaneous accept at the output and load from upstream in one cycle: there is no bubble and no loss.
- Reset asserted mid-operation: all in-flight products are discarded immediately (asynchronous). After release, the first transfer is possible on the next edge.

## Configuration
- `BOOTH_WALLACE_OUT_REG_EN` defined:
  - The CPA result is captured in `out_reg` with `out_v`.
  - Three register stages, latency 3.
  - `product` is registered.
- `BOOTH_WALLACE_OUT_REG_EN` undefined:
  - `product` = `s2_sum` + `s2_carry`, computed combinationally.
  - `out_valid` = `s2_v`.
  - Two register stages, latency 2.

## Structure
- Package `booth_mult_pkg` holds:
  - constants `PP_W`=17, `P_W`=32, `PP_NUM`=8;
  - the weight-shift constant (2 per row);
  - a `row_t` (32-bit) typedef.
- Sub-module `csa_3_2`: a width-parameterised 3:2 carry-save adder.
  - Outputs: sum = a^b^c, carry = majority shifted left by 1, bit 0 = 0.
  - Instantiated 6 times.

## Test plan
- PP1=17'h1FFFB, PP2=17'h00005, others 0, accepted once → after latency, `product`=32'h0000000F.
- All PPi=17'h00001 → `product`=32'h00005555.
- PP8=17'h1FFFF, others 0 → `product`=32'hFFFFC000. PP1=17'h0FFFF, others 0 → 32'h0000FFFF.
- Back-to-back stream of 8 random PP sets with `out_ready`=1 → 8 consecutive correct products against the model, one per cycle, in order.
- Hold `out_ready`=0 while feeding inputs → `in_ready` falls after 3 (or 2) accepts, `product` stable. Release → drains in order with no loss or duplication.
- Assert `sys_rst_n`=0 with 2 products in flight → `out_valid`=0 immediately. After release, no stale product appears and the next input yields its correct result.
